// File: rtl/prf_wr_arbiter.sv
// rtl/prf_wr_arbiter.sv - round-robin arbiter of PRF write requesters onto banked PRF write ports
//
// Each requester owns a small in-order input FIFO. Every cycle, each PRF bank grants at most
// one FIFO head that targets it. A per-bank round-robin pointer selects the winner.
// The bank of a write is PR[LOG_PRF_BANK_COUNT-1:0].
//
// Optional feature macro: PRF_WR_ARBITER_BYPASS_EN
//   When defined, an empty requester with valid=1 presents its input as the candidate in the
//   same cycle. A granted bypass write is never enqueued.
//
// Ports:
//   CLK, nRST                    clock, asynchronous active-low reset
//   write_req_valid_by_wr        requester offers a write
//   write_req_PR_by_wr           destination physical register
//   write_req_data_by_wr         write data
//   write_req_ready_by_wr        requester buffer has space (from registered count only)
//   bank_write_valid_by_bank     bank performs a write this cycle
//   bank_write_upper_PR_by_bank  PR bits above the bank index
//   bank_write_data_by_bank      write data
//   bank_write_src_by_bank       index of the winning requester
module prf_wr_arbiter #(
    parameter int PRF_WR_COUNT             = 8,
    parameter int PRF_BANK_COUNT           = 4,
    parameter int PR_COUNT                 = 128,
    parameter int XLEN                     = 32,
    parameter int PRF_WR_INPUT_BUFFER_SIZE = 2,
    parameter int LOG_PR_COUNT             = $clog2(PR_COUNT),
    parameter int LOG_PRF_BANK_COUNT       = $clog2(PRF_BANK_COUNT),
    parameter int LOG_PRF_WR_COUNT         = $clog2(PRF_WR_COUNT)
) (
    input  logic                                                         CLK,
    input  logic                                                         nRST,
    input  logic [PRF_WR_COUNT-1:0]                                      write_req_valid_by_wr,
    input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]                    write_req_PR_by_wr,
    input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]                            write_req_data_by_wr,
    output logic [PRF_WR_COUNT-1:0]                                      write_req_ready_by_wr,
    output logic [PRF_BANK_COUNT-1:0]                                    bank_write_valid_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] bank_write_upper_PR_by_bank,
    output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]                          bank_write_data_by_bank,
    output logic [PRF_BANK_COUNT-1:0][LOG_PRF_WR_COUNT-1:0]              bank_write_src_by_bank
);

    localparam int PTR_W = (PRF_WR_INPUT_BUFFER_SIZE > 1) ? $clog2(PRF_WR_INPUT_BUFFER_SIZE) : 1;
    localparam int CNT_W = $clog2(PRF_WR_INPUT_BUFFER_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PRF_WR_INPUT_BUFFER_SIZE);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(PRF_WR_INPUT_BUFFER_SIZE - 1);
    localparam logic [LOG_PRF_WR_COUNT-1:0] WR_LAST = LOG_PRF_WR_COUNT'(PRF_WR_COUNT - 1);

    logic [LOG_PR_COUNT-1:0]     buf_pr   [PRF_WR_COUNT][PRF_WR_INPUT_BUFFER_SIZE];
    logic [XLEN-1:0]             buf_data [PRF_WR_COUNT][PRF_WR_INPUT_BUFFER_SIZE];
    logic [CNT_W-1:0]            count    [PRF_WR_COUNT];
    logic [PTR_W-1:0]            head     [PRF_WR_COUNT];
    logic [PTR_W-1:0]            tail     [PRF_WR_COUNT];
    logic [LOG_PRF_WR_COUNT-1:0] rr_ptr   [PRF_BANK_COUNT];

    logic [PRF_WR_COUNT-1:0]     cand_valid;
    logic [PRF_WR_COUNT-1:0]     cand_bypass;
    logic [LOG_PR_COUNT-1:0]     cand_pr   [PRF_WR_COUNT];
    logic [XLEN-1:0]             cand_data [PRF_WR_COUNT];
    logic [PRF_BANK_COUNT-1:0]   bank_grant;
    logic [LOG_PRF_WR_COUNT-1:0] bank_winner [PRF_BANK_COUNT];
    logic [PRF_WR_COUNT-1:0]     granted;
    logic [PRF_WR_COUNT-1:0]     enq;
    logic [PRF_WR_COUNT-1:0]     deq;

    // Candidate per requester: its FIFO head, or (bypass builds) the live input when empty.
    always_comb begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            write_req_ready_by_wr[i] = (count[i] < CNT_FULL);
            cand_valid[i]  = (count[i] != '0);
            cand_bypass[i] = 1'b0;
            cand_pr[i]     = buf_pr[i][head[i]];
            cand_data[i]   = buf_data[i][head[i]];
`ifdef PRF_WR_ARBITER_BYPASS_EN
            if ((count[i] == '0) && write_req_valid_by_wr[i]) begin
                cand_valid[i]  = 1'b1;
                cand_bypass[i] = 1'b1;
                cand_pr[i]     = write_req_PR_by_wr[i];
                cand_data[i]   = write_req_data_by_wr[i];
            end
`endif
        end
    end

    // Per-bank round-robin: first eligible requester at or after rr_ptr, wrapping.
    always_comb begin
        logic [LOG_PRF_WR_COUNT-1:0] idx;
        idx = '0;
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            bank_grant[b]  = 1'b0;
            bank_winner[b] = '0;
            for (int k = 0; k < PRF_WR_COUNT; k++) begin
                idx = LOG_PRF_WR_COUNT'((int'(rr_ptr[b]) + k) % PRF_WR_COUNT);
                if (!bank_grant[b] && cand_valid[idx] &&
                    (cand_pr[idx][LOG_PRF_BANK_COUNT-1:0] == LOG_PRF_BANK_COUNT'(b))) begin
                    bank_grant[b]  = 1'b1;
                    bank_winner[b] = idx;
                end
            end
        end
    end

    // A requester targets a single bank, so at most one bank can grant it.
    always_comb begin
        granted = '0;
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (bank_grant[b] && (bank_winner[b] == LOG_PRF_WR_COUNT'(i))) begin
                    granted[i] = 1'b1;
                end
            end
            deq[i] = granted[i] && !cand_bypass[i];
            enq[i] = write_req_valid_by_wr[i] && write_req_ready_by_wr[i] &&
                     !(granted[i] && cand_bypass[i]);
        end
    end

    always_comb begin
        for (int b = 0; b < PRF_BANK_COUNT; b++) begin
            bank_write_valid_by_bank[b]    = bank_grant[b];
            bank_write_upper_PR_by_bank[b] = '0;
            bank_write_data_by_bank[b]     = '0;
            bank_write_src_by_bank[b]      = '0;
            if (bank_grant[b]) begin
                bank_write_upper_PR_by_bank[b] = cand_pr[bank_winner[b]][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
                bank_write_data_by_bank[b]     = cand_data[bank_winner[b]];
                bank_write_src_by_bank[b]      = bank_winner[b];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                rr_ptr[b] <= '0;
            end
        end else begin
            for (int b = 0; b < PRF_BANK_COUNT; b++) begin
                if (bank_grant[b]) begin
                    rr_ptr[b] <= (bank_winner[b] == WR_LAST) ? '0 : bank_winner[b] + 1'b1;
                end
            end
            for (int i = 0; i < PRF_WR_COUNT; i++) begin
                if (enq[i]) begin
                    tail[i] <= (tail[i] == PTR_LAST) ? '0 : tail[i] + 1'b1;
                end
                if (deq[i]) begin
                    head[i] <= (head[i] == PTR_LAST) ? '0 : head[i] + 1'b1;
                end
                case ({enq[i], deq[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // Buffer storage needs no reset: entries are only observed while count covers them.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < PRF_WR_COUNT; i++) begin
            if (enq[i]) begin
                buf_pr[i][tail[i]]   <= write_req_PR_by_wr[i];
                buf_data[i][tail[i]] <= write_req_data_by_wr[i];
            end
        end
    end

endmodule

// File: tb/tb_prf_wr_arbiter.sv
// tb/tb_prf_wr_arbiter.sv - self-checking bench for prf_wr_arbiter with queue-based reference model
module tb_prf_wr_arbiter;

    localparam int NW = 8;
    localparam int NB = 4;
`ifdef PRF_WR_ARBITER_BYPASS_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    typedef struct packed {
        logic [6:0]  pr;
        logic [31:0] data;
    } ent_t;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [NW-1:0]        v;
    logic [NW-1:0][6:0]   pr;
    logic [NW-1:0][31:0]  data;
    logic [NW-1:0]        rdy;
    logic [NB-1:0]        bv;
    logic [NB-1:0][4:0]   bup;
    logic [NB-1:0][31:0]  bd;
    logic [NB-1:0][2:0]   bsrc;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t q [NW][$];
    int   rr [NB];

    prf_wr_arbiter dut (
        .CLK                         (CLK),
        .nRST                        (nRST),
        .write_req_valid_by_wr       (v),
        .write_req_PR_by_wr          (pr),
        .write_req_data_by_wr        (data),
        .write_req_ready_by_wr       (rdy),
        .bank_write_valid_by_bank    (bv),
        .bank_write_upper_PR_by_bank (bup),
        .bank_write_data_by_bank     (bd),
        .bank_write_src_by_bank      (bsrc)
    );

    always #5 CLK = ~CLK;

    // Reference model + scoreboard: per-requester queues of accepted writes, popped when granted.
    always @(negedge CLK) begin
        logic [NW-1:0] e_rdy;
        bit            cv [NW];
        bit            byp [NW];
        bit            g [NW];
        ent_t          c [NW];
        ent_t          e;
        int            win [NB];
        int            idx;
        logic [40:0]   got, exp;
        if (!nRST) begin
            for (int i = 0; i < NW; i++) q[i].delete();
            for (int b = 0; b < NB; b++) rr[b] = 0;
        end
        for (int i = 0; i < NW; i++) begin
            e_rdy[i] = (q[i].size() < 2);
            cv[i] = 0; byp[i] = 0; g[i] = 0; c[i] = '0;
            if (q[i].size() > 0) begin
                c[i] = q[i][0]; cv[i] = 1;
            end
`ifdef PRF_WR_ARBITER_BYPASS_EN
            else if (v[i]) begin
                c[i].pr = pr[i]; c[i].data = data[i]; cv[i] = 1; byp[i] = 1;
            end
`endif
        end
        for (int b = 0; b < NB; b++) begin
            win[b] = -1;
            for (int k = 0; k < NW; k++) begin
                idx = (rr[b] + k) % NW;
                if (win[b] < 0 && cv[idx] && (int'(c[idx].pr) % NB == b)) win[b] = idx;
            end
        end
        n_checks++;
        if (rdy !== e_rdy) begin
            n_fail++;
            $display("FAIL ready t=%0t got=%b exp=%b", $time, rdy, e_rdy);
        end
        for (int b = 0; b < NB; b++) begin
            got = {bv[b], bup[b], bd[b], bsrc[b]};
            if (win[b] < 0) exp = '0;
            else exp = {1'b1, 5'(int'(c[win[b]].pr) / NB), c[win[b]].data, 3'(win[b])};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL bank%0d t=%0t got(v,up,data,src)=%h exp=%h", b, $time, got, exp);
            end
        end
        if (nRST) begin
            for (int b = 0; b < NB; b++) begin
                if (win[b] >= 0) begin
                    rr[b] = (win[b] + 1) % NW;
                    g[win[b]] = 1;
                    if (!byp[win[b]]) void'(q[win[b]].pop_front());
                end
            end
            for (int i = 0; i < NW; i++) begin
                if (v[i] && e_rdy[i] && !(g[i] && byp[i])) begin
                    e.pr = pr[i]; e.data = data[i];
                    q[i].push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        v = '0;
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit model_empty();
        for (int i = 0; i < NW; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    initial begin
        int drained;
        v = '0; pr = '0; data = '0;
        nRST = 1'b0;
        #2;
        chk("reset_ready", 64'(rdy), 64'hFF);
        chk("reset_bank_valid", 64'(bv), 64'h0);
        do_reset();

        // Single write: requester 3, PR 0x29 -> bank 1, upper 0x0A
        v[3] = 1'b1; pr[3] = 7'h29; data[3] = 32'hDEADBEEF;
        @(negedge CLK);
        chk("single_same_cycle_valid", 64'(bv[1]), (OFF == 0) ? 64'h1 : 64'h0);
        tick();
        v = '0;
        if (OFF == 1) begin
            @(negedge CLK);
            chk("single_valid", 64'(bv), 64'h2);
            chk("single_upper", 64'(bup[1]), 64'h0A);
            chk("single_data", 64'(bd[1]), 64'hDEADBEEF);
            chk("single_src", 64'(bsrc[1]), 64'h3);
        end
        tick();
        tick();

        // Backpressure: push rr_ptr[0] past 0, then requester 0 fights the others for bank 0
        for (int i = 1; i < NW; i++) begin
            v[i] = 1'b1; pr[i] = 7'(i * 4);
        end
        tick(); tick(); tick();
        v[0] = 1'b1; pr[0] = 7'h40;
        for (int c = 0; c < 10; c++) begin
            data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        v = '0;
        for (int c = 0; c < 20; c++) tick();

        // Round-robin fairness from reset: everyone targets bank 2
        do_reset();
        for (int i = 0; i < NW; i++) begin
            v[i] = 1'b1; pr[i] = {5'(i), 2'b10};
        end
        for (int j = 0; j < 18; j++) begin
            @(negedge CLK);
            if (j >= OFF) begin
                chk($sformatf("rr_valid_c%0d", j), 64'(bv[2]), 64'h1);
                chk($sformatf("rr_src_c%0d", j), 64'(bsrc[2]), 64'((j - OFF) % NW));
            end
            tick();
        end
        v = '0;
        for (int c = 0; c < 20; c++) tick();

        // Parallel banks: requesters 0..3 hit banks 0..3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            v[i] = 1'b1; pr[i] = {5'(i + 8), 2'(i)}; data[i] = 32'hA000_0000 + 32'(i);
        end
        if (OFF == 1) begin
            tick();
            v = '0;
            @(negedge CLK);
        end else begin
            @(negedge CLK);
        end
        chk("parallel_valid", 64'(bv), 64'hF);
        chk("parallel_src", 64'(bsrc), {52'h0, 3'd3, 3'd2, 3'd1, 3'd0});
        tick();
        v = '0;
        tick();

        // Requester 5 streams to an uncontended bank across pointer wrap
        for (int c = 0; c < 10; c++) begin
            v[5] = 1'b1; pr[5] = 7'h11; data[5] = 32'h5500 + 32'(c);
            @(negedge CLK);
            chk($sformatf("stream_ready_c%0d", c), 64'(rdy[5]), 64'h1);
            tick();
        end
        v = '0;
        tick(); tick();

        // Bypass candidates: idle bank 3, then bank 3 held by a higher-priority head
        v[6] = 1'b1; pr[6] = 7'h03; data[6] = 32'h6666_0001;
        tick();
        v = '0;
        tick(); tick();
        v[2] = 1'b1; pr[2] = 7'h07; data[2] = 32'h2222_0001;
        v[1] = 1'b1; pr[1] = 7'h0B; data[1] = 32'h1111_0001;
        tick();
        v = '0;
        v[6] = 1'b1; pr[6] = 7'h03; data[6] = 32'h6666_0002;
        tick();
        v = '0;
        for (int c = 0; c < 10; c++) tick();

        // Randomized traffic with a mid-operation reset
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                v = '0;
                nRST = 1'b0;
                tick();
                nRST = 1'b1;
            end
            for (int i = 0; i < NW; i++) begin
                v[i] = ($urandom_range(0, 99) < 55);
                pr[i] = (c < 400) ? {5'($urandom), 2'($urandom_range(0, 1))} : 7'($urandom);
                data[i] = $urandom;
            end
            tick();
        end
        v = '0;

        // Drain: every accepted write must eventually reach a bank
        drained = 0;
        for (int c = 0; c < 100 && !drained; c++) begin
            tick();
            if (model_empty()) drained = 1;
        end
        n_checks++;
        if (!drained) begin
            n_fail++;
            $display("FAIL drain got=pending exp=empty");
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
